// File: rtl/rom_vram_loader.sv
// rom_vram_loader: copies the boot/font ROM image into VRAM once after power-up,
// after a start-up wait, one byte per VRAM write through a req/ack handshake.
module rom_vram_loader #(
   parameter int unsigned             RAM_SIZE    = 4096,
   parameter int unsigned             DST_AW      = 14,
   parameter logic [DST_AW-1:0]       DST_BASE    = 14'h0800,
   parameter int unsigned             WAIT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        restart,
   output logic [$clog2(RAM_SIZE)-1:0] rom_addr,
   input  logic [7:0]                  rom_data,
   output logic                        wr_req,
   input  logic                        wr_ack,
   output logic [DST_AW-1:0]           wr_addr,
   output logic [7:0]                  wr_data,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned AW = $clog2(RAM_SIZE);
   localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_WAIT  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [AW-1:0]       idx, idx_n;
   logic                wr_req_n;
   logic [DST_AW-1:0]   wr_addr_n;
   logic [7:0]          wr_data_n;
   logic                busy_n;
   logic                done_n;

   // The byte index doubles as the ROM address.
   assign rom_addr = idx;

   // State and registered outputs; reset also abandons any pending write request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_WAIT;
         cnt     <= '0;
         idx     <= '0;
         wr_req  <= 1'b0;
         wr_addr <= DST_BASE;
         wr_data <= 8'h00;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         wr_req  <= wr_req_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   // Next-state and next-output logic for the wait / fetch / latch / write sequence.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      wr_req_n  = wr_req;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;

      case (state)
         S_WAIT: begin
            if (cnt == CW'(WAIT_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = S_FETCH;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_FETCH: begin
            state_n = S_LATCH;
         end
         S_LATCH: begin
            wr_data_n = rom_data;
            wr_addr_n = DST_BASE + DST_AW'(idx);
            wr_req_n  = 1'b1;
            state_n   = S_WRITE;
         end
         S_WRITE: begin
            if (wr_ack) begin
               wr_req_n = 1'b0;
               if (idx == AW'(RAM_SIZE - 1)) begin
                  state_n = S_DONE;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = S_FETCH;
               end
            end
         end
         S_DONE: begin
            wr_req_n = 1'b0;
            if (restart) begin
               idx_n   = '0;
               state_n = S_FETCH;
            end
         end
         default: begin
            state_n  = S_WAIT;
            cnt_n    = '0;
            idx_n    = '0;
            wr_req_n = 1'b0;
         end
      endcase

      busy_n = (state_n != S_DONE);
      done_n = (state_n == S_DONE);
   end

endmodule

// File: doc/rom_vram_loader.md
Name: rom_vram_loader

Overview:
- Copies the initialized font/boot ROM image into VRAM once after power-up, sitting directly downstream of the registered-read ROM block.
- Drives the ROM address, captures the ROM's registered read data, and issues one VRAM write per byte through a req/ack handshake to the VRAM arbiter.
- Includes a start-up wait counter, because iCE40 initialized sysMEM is not reliably readable immediately after configuration.

Parameters:
- RAM_SIZE, 4096, number of ROM bytes to copy; must be ≥2. ROM address width is $clog2(RAM_SIZE).
- DST_AW, 14, VRAM address width.
- DST_BASE, 14'h0800, VRAM address receiving ROM byte 0.
- WAIT_CYCLES, 1024, clk cycles to wait after reset before the first ROM read; must be ≥1.

Ports:
- clk  in  1  system clock; also clocks the ROM.
- reset  in  1  asynchronous, active-high reset.
- restart  in  1  one-cycle pulse; re-runs the copy, honoured only in DONE.
- rom_addr  out  $clog2(RAM_SIZE)  ROM read address.
- rom_data  in  8  ROM read data; valid the cycle after rom_addr is presented.
- wr_req  out  1  VRAM write request.
- wr_ack  in  1  VRAM write accepted; sampled only while wr_req=1.
- wr_addr  out  DST_AW  VRAM write address.
- wr_data  out  8  VRAM write data.
- busy  out  1  copy in progress, including the wait phase.
- done  out  1  copy complete.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state=WAIT, wait counter=0, idx=0, rom_addr=0, wr_req=0, wr_addr=DST_BASE, wr_data=0, busy=1, done=0.
- rom_addr is always the idx register. wr_addr is registered as (DST_BASE+idx) truncated to DST_AW bits, so it wraps modulo 2^DST_AW.
- State WAIT:
  - Counter increments each cycle.
  - When counter reaches WAIT_CYCLES-1, go to FETCH. The first FETCH cycle is therefore WAIT_CYCLES cycles after reset release.
- State FETCH: rom_addr=idx is stable; the ROM samples it at this edge. Go to LATCH.
- State LATCH:
  - rom_data is valid; register it into wr_data.
  - Register wr_addr=DST_BASE+idx.
  - Set wr_req=1 and go to WRITE.
- State WRITE:
  - Hold wr_req, wr_addr and wr_data stable until wr_ack=1 is sampled at a clk edge.
  - On ack: wr_req=0. If idx==RAM_SIZE-1, go to DONE. Otherwise idx=idx+1 and go to FETCH.
  - wr_ack may already be high in the first WRITE cycle, giving a single-cycle write.
- Throughput: at least 3 cycles per byte (FETCH, LATCH, WRITE).
- State DONE: busy=0, done=1, wr_req=0. restart=1 clears idx to 0, sets done=0 and busy=1, and goes straight to FETCH without repeating WAIT.
- Ignored inputs:
  - restart in any state other than DONE is ignored.
  - wr_ack while wr_req=0 is ignored and must not advance anything.
- idx never wraps. The copy ends exactly after writing byte RAM_SIZE-1; no write is issued for index RAM_SIZE.
- busy is 1 in WAIT/FETCH/LATCH/WRITE. done is 1 only in DONE. Both are registered and never high together.
- Reset mid-operation, including mid-handshake with wr_req=1: wr_req drops immediately (asynchronously) and the sequence restarts from WAIT with idx=0. The arbiter must tolerate an abandoned request.
- Invalid or unused state encodings fall back to WAIT.

Test Plan:
- Params RAM_SIZE=16, WAIT_CYCLES=4, DST_BASE=14'h0800; ROM model registered, contents mem[i]=8'hA0+i; wr_ack tied high -> wr_req first asserts 6 cycles after reset release; 16 writes, addr 0x0800..0x080F, data A0..AF, each 3 cycles apart; done=1 and busy=0 after the 16th ack; no 17th write.
- Same setup, wr_ack delayed by random 0–5 cycles per request -> wr_addr and wr_data constant while wr_req=1; exactly one VRAM write per ack; final VRAM image identical to the ROM.
- DST_BASE=14'h3FF8, RAM_SIZE=16 -> write addresses 3FF8..3FFF then 0000..0007 (wrap).
- After done=1, wr_ack held high for 10 idle cycles, then restart pulse -> no spurious writes while idle; after restart, busy=1 and done=0 next cycle, first wr_req appears 2 cycles later (no WAIT phase); full 16-byte copy repeats.
- restart pulsed during WAIT and during WRITE -> ignored; sequence and write count unchanged.
- reset asserted while wr_req=1 at byte 7, held 2 cycles -> wr_req falls without waiting for a clock edge; after release, WAIT repeats and copying restarts at byte 0 (addr 0x0800, data A0).
